output_unit_reader: RTL and testbench

- Downstream drain stage for ram_output_unit.
- On a start command, it walks RAM addresses 0..len-1 and accounts for the RAM's one-cycle registered-address read latency.
- Each byte read is pushed into a 2-entry output buffer and presented on a valid/ready stream to the next consumer, such as a UART TX or host interface.
- Sustains 1 byte/cycle when the consumer is always ready.

---
 rtl/output_unit_reader_if.sv | 21 ++
 rtl/output_unit_reader.sv | 133 +++++++++++++
 tb/tb_output_unit_reader.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/output_unit_reader_if.sv
// Byte stream from the reader to its consumer.
// The master drives data and valid; the slave drives ready.
interface output_unit_reader_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/output_unit_reader.sv
// Drains ram_output_unit addresses 0..len-1 into a 2-entry FIFO.
// The FIFO drives a valid/ready byte stream and hides the one-cycle RAM read latency.
module output_unit_reader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    len,
  output logic [ADDR_W-1:0]    ram_addr,
  input  logic [DATA_W-1:0]    ram_q,
  output_unit_reader_if.master out_if,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic       pop;
  logic       issue;
  logic       len_ok;
  logic       wr_idx;
  logic [1:0] occ;

  assign len_ok = (len != '0) && (32'(len) <= DEPTH);
  assign occ    = count_q + 2'(inflight_q);
  assign pop    = out_if.out_valid & out_if.out_ready;

  // A slot freed by this cycle's pop may be refilled now; that keeps 1 byte/cycle.
  assign issue = (state_q == StRun) && (issued_q < len_q) &&
                 ((occ < 2'd2) || ((occ == 2'd2) && pop));

  assign ram_addr = issue ? issued_q : addr_q;
  assign wr_idx   = count_q[0] & ~pop;

  assign out_if.out_valid = (count_q != 2'd0);
  assign out_if.out_data  = buf_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = issued_q + ADDR_W'(issue);
    addr_d     = ram_addr;
    inflight_d = issue;
    count_d    = count_q + 2'(inflight_q) - 2'(pop);
    buf_d      = buf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (pop) begin
      buf_d[0] = buf_q[1];
    end
    if (inflight_q) begin
      buf_d[wr_idx] = ram_q;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len_ok) begin
            state_d  = StRun;
            len_d    = len;
            issued_d = '0;
            busy_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (pop && (count_q == 2'd1) && !inflight_q && (issued_q == len_q)) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      issued_q   <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_output_unit_reader.sv
// Randomized bench for output_unit_reader against a transfer-timing reference model.
// The model derives issue and transfer cycles from the read-ahead and ready rules.
module tb_output_unit_reader;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 9;
  localparam int NCYC   = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] len = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_q = '0;
  logic              busy, done, err;

  output_unit_reader_if #(.DATA_W(DATA_W)) st_if ();

  output_unit_reader #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .ram_addr(ram_addr),
    .ram_q   (ram_q),
    .out_if  (st_if),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  logic [DATA_W-1:0] ram [16];
  logic              rdy [NCYC];

  always #5 clk = ~clk;
  always @(posedge clk) ram_q <= ram[ram_addr];

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] got[$];
  int                xfer_cyc[$];
  logic [ADDR_W-1:0] addr_tr[$];
  int                done_tr[$];
  int                exp_t[$];
  int                exp_i[$];
  int busy_cnt, busy_min, busy_max, err_cnt, stall_bad, max_addr;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    st_if.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_rdy(input int pct);
    for (int c = 0; c < NCYC; c++) begin
      rdy[c] = (c > 150) ? 1'b1 : ($urandom_range(0, 99) < pct);
    end
  endtask

  // Byte k issues once k-2 has left (pops count in their own cycle) and one cycle
  // after k-1; it can transfer two cycles after issue, after k-1, on a ready cycle.
  function automatic void model(input int n);
    exp_t.delete();
    exp_i.delete();
    for (int k = 0; k < n; k++) begin
      int ik;
      int tk;
      ik = (k == 0) ? 1 : exp_i[k-1] + 1;
      if (k >= 2 && exp_t[k-2] > ik) ik = exp_t[k-2];
      tk = ik + 2;
      if (k >= 1 && exp_t[k-1] + 1 > tk) tk = exp_t[k-1] + 1;
      while (tk < NCYC - 1 && !rdy[tk]) tk++;
      exp_i.push_back(ik);
      exp_t.push_back(tk);
    end
  endfunction

  // Starts a drain in cycle 0 and records what the DUT does; sa/sb inject extra starts.
  task automatic drain(input int n, input int sa, input int sb, input int ncyc);
    logic pv, pr;
    logic [DATA_W-1:0] pd;
    got.delete(); xfer_cyc.delete(); addr_tr.delete(); done_tr.delete();
    busy_cnt = 0; busy_min = NCYC; busy_max = -1; err_cnt = 0; stall_bad = 0; max_addr = 0;
    pv = 1'b0; pr = 1'b1; pd = '0;
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == sa) || (c == sb);
      len = (c == 0) ? ADDR_W'(n) : ADDR_W'(2);
      st_if.out_ready = rdy[c];
      #1;
      addr_tr.push_back(ram_addr);
      if (busy === 1'b1) begin
        busy_cnt++;
        if (c < busy_min) busy_min = c;
        if (c > busy_max) busy_max = c;
        if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
      end
      if (done === 1'b1) done_tr.push_back(c);
      if (err === 1'b1) err_cnt++;
      if (pv && !pr && (st_if.out_valid !== 1'b1 || st_if.out_data !== pd)) stall_bad++;
      if (st_if.out_valid === 1'b1 && st_if.out_ready === 1'b1) begin
        got.push_back(st_if.out_data);
        xfer_cyc.push_back(c);
      end
      pv = st_if.out_valid;
      pr = st_if.out_ready;
      pd = st_if.out_data;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_drain(input string name, input int n, input int sa, input int sb);
    int last, m;
    model(n);
    last = exp_t[n-1];
    drain(n, sa, sb, last + 4);
    vectors++;
    if (got.size() != n) begin
      miscompares++;
      $display("FAIL %s_count: got %0d bytes want %0d", name, got.size(), n);
    end
    m = (got.size() < n) ? got.size() : n;
    for (int k = 0; k < m; k++) begin
      vectors++;
      if (got[k] !== ram[k]) begin
        miscompares++;
        $display("FAIL %s_data%0d: got %h want %h", name, k, got[k], ram[k]);
      end
      vectors++;
      if (xfer_cyc[k] != exp_t[k]) begin
        miscompares++;
        $display("FAIL %s_cycle%0d: got %0d want %0d", name, k, xfer_cyc[k], exp_t[k]);
      end
    end
    for (int k = 0; k < n; k++) begin
      vectors++;
      if (addr_tr[exp_i[k]] !== ADDR_W'(k)) begin
        miscompares++;
        $display("FAIL %s_addr%0d: got %0d want %0d at cycle %0d", name, k,
                 addr_tr[exp_i[k]], k, exp_i[k]);
      end
    end
    vectors++;
    if (done_tr.size() != 1 || done_tr[0] != last + 1) begin
      miscompares++;
      $display("FAIL %s_done: got %0d pulses first %0d want 1 at %0d", name, done_tr.size(),
               (done_tr.size() > 0) ? done_tr[0] : -1, last + 1);
    end
    vectors++;
    if (busy_cnt != last || busy_min != 1 || busy_max != last) begin
      miscompares++;
      $display("FAIL %s_busy: got %0d cycles %0d..%0d want 1..%0d", name, busy_cnt,
               busy_min, busy_max, last);
    end
    vectors++;
    if (stall_bad != 0) begin
      miscompares++;
      $display("FAIL %s_stall_hold: got %0d changes want 0", name, stall_bad);
    end
    vectors++;
    if (max_addr >= n) begin
      miscompares++;
      $display("FAIL %s_addr_range: got max %0d want < %0d", name, max_addr, n);
    end
    vectors++;
    if (err_cnt != 0) begin
      miscompares++;
      $display("FAIL %s_err: got %0d pulses want 0", name, err_cnt);
    end
  endtask

  task automatic test_reset();
    start = 1'b1; len = 4'd4; st_if.out_ready = 1'b1; rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({ram_addr, st_if.out_data, st_if.out_valid, busy, done, err} !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0",
               {ram_addr, st_if.out_data, st_if.out_valid, busy, done, err});
    end
    start = 1'b0; rst_n = 1'b1;
    tick();
    vectors++;
    if ({busy, st_if.out_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_idle: got %b want 00", {busy, st_if.out_valid});
    end
  endtask

  task automatic test_bad_len();
    int bad_lens[3];
    bad_lens = '{0, 10, 15};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; len = ADDR_W'(bad_lens[i]);
      tick();
      start = 1'b0;
      vectors++;
      if ({err, busy, st_if.out_valid, ram_addr} !== 7'b1000000) begin
        miscompares++;
        $display("FAIL bad_len%0d_err: got %b want 1000000", bad_lens[i],
                 {err, busy, st_if.out_valid, ram_addr});
      end
      tick();
      vectors++;
      if ({err, busy, st_if.out_valid, ram_addr} !== 7'b0) begin
        miscompares++;
        $display("FAIL bad_len%0d_after: got %b want 0000000", bad_lens[i],
                 {err, busy, st_if.out_valid, ram_addr});
      end
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
    set_rdy(100);
    test_drain("basic", 4, -1, -1);
  endtask

  task automatic test_backpressure();
    int mx;
    set_rdy(100);
    for (int c = 3; c <= 7; c++) rdy[c] = 1'b0;
    test_drain("backpressure", 4, -1, -1);
    mx = 0;
    for (int c = 1; c <= 7; c++) if (int'(addr_tr[c]) > mx) mx = int'(addr_tr[c]);
    vectors++;
    if (mx != 1) begin
      miscompares++;
      $display("FAIL backpressure_readahead: got max addr %0d want 1", mx);
    end
  endtask

  task automatic test_full_len();
    for (int i = 0; i < 16; i++) ram[i] = 8'(8'hA0 + i);
    set_rdy(100);
    test_drain("full_len", DEPTH, -1, -1);
    vectors++;
    if (max_addr != DEPTH - 1) begin
      miscompares++;
      $display("FAIL full_len_last_addr: got %0d want %0d", max_addr, DEPTH - 1);
    end
  endtask

  task automatic test_start_during_busy();
    for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
    set_rdy(100);
    // Extra starts mid-drain (cycle 3) and in the DONE cycle (cycle 8).
    test_drain("busy_start", 5, 3, 8);
  endtask

  task automatic test_reset_mid();
    int bad;
    for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
    set_rdy(100);
    start = 1'b1; len = 4'd5; st_if.out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if ({st_if.out_valid, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_state: got %b want 000", {st_if.out_valid, busy, done});
    end
    bad = 0;
    repeat (4) begin
      tick();
      if (st_if.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: got %0d active cycles want 0", bad);
    end
    test_drain("after_reset", 1, -1, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < 16; i++) ram[i] = 8'($urandom);
      set_rdy($urandom_range(25, 100));
      test_drain($sformatf("random%0d", it), n, -1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_bad_len();
    test_basic();
    test_backpressure();
    test_full_len();
    test_start_during_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
